// File: rtl/wvb_reader_if.sv
// Waveform word stream from the buffer reader to its consumer.
interface wvb_reader_if #(
    parameter int P_DATA_WIDTH = 22
);
    logic [P_DATA_WIDTH-1:0] dout;
    logic                    dout_valid;
    logic                    dout_last;
    logic                    dout_ready;

    modport master (output dout, output dout_valid, output dout_last, input dout_ready);
    modport slave  (input dout, input dout_valid, input dout_last, output dout_ready);
endinterface

// File: rtl/wvb_reader.sv
// Consumer side of the waveform buffer: reads one event (header + words
// start_addr..stop_addr, wrapping) and streams it out, then pops the header
// and pulses wvb_rddone so the overflow control can free the space.
module wvb_reader #(
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_DATA_WIDTH = 22,
    parameter int P_HDR_WIDTH  = 80
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [P_HDR_WIDTH-1:0]  hdr_data,
    input  logic                    hdr_empty,
    output logic                    hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
    input  logic [P_DATA_WIDTH-1:0] wvb_data,
    output logic                    wvb_rddone,
    wvb_reader_if.master            dout_if,
    output logic [47:0]             evt_ltc,
    output logic [1:0]              evt_trig_src,
    output logic                    evt_cnst_run,
    output logic [4:0]              evt_pre_conf,
    output logic [P_ADR_WIDTH:0]    evt_len,
    output logic                    busy
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

    localparam logic [P_ADR_WIDTH:0]   LEN_ONE = 1;
    localparam logic [P_ADR_WIDTH-1:0] ADR_ONE = 1;

    state_t                  state_q, state_d;
    logic [P_ADR_WIDTH-1:0]  addr_q, addr_d;
    logic [P_ADR_WIDTH:0]    rem_q, rem_d;        // addresses still to issue
    logic                    pend_q, pend_d;      // RAM word arriving this cycle
    logic                    pend_last_q, pend_last_d;
    logic [1:0]              cnt_q, cnt_d;        // skid occupancy
    logic [P_DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic                    l0_q, l0_d, l1_q, l1_d;
    logic [47:0]             ltc_q, ltc_d;
    logic [1:0]              trig_q, trig_d;
    logic                    cnst_q, cnst_d;
    logic [4:0]              pre_q, pre_d;
    logic [P_ADR_WIDTH:0]    len_q, len_d;
    logic                    rdreq_q, rdreq_d;
    logic                    busy_q, busy_d;

    logic [P_ADR_WIDTH-1:0]  hdr_start, hdr_stop, hdr_diff;
    logic [P_ADR_WIDTH:0]    hdr_len;
    logic                    push, pop, issue;
    logic [1:0]              occ;

    assign hdr_start = hdr_data[20 +: P_ADR_WIDTH];
    assign hdr_stop  = hdr_data[8 +: P_ADR_WIDTH];
    assign hdr_diff  = hdr_stop - hdr_start;
    // stop == start-1 yields the full 2^P_ADR_WIDTH buffer
    assign hdr_len   = {1'b0, hdr_diff} + LEN_ONE;

    assign push = pend_q;
    assign pop  = (cnt_q != 2'd0) && dout_if.dout_ready;
    // occupancy at the moment the next issued word would land, assuming no pop then
    assign occ   = cnt_q + {1'b0, push} - {1'b0, pop};
    assign issue = ((state_q == S_LOAD) || (state_q == S_STREAM)) &&
                   (rem_q != '0) && (occ <= 2'd1);

    // Next-state: FSM, address issue and the 2-entry skid buffer
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        pend_d      = issue;
        pend_last_d = issue && (rem_q == LEN_ONE);
        cnt_d       = cnt_q;
        e0_d        = e0_q;
        e1_d        = e1_q;
        l0_d        = l0_q;
        l1_d        = l1_q;
        ltc_d       = ltc_q;
        trig_d      = trig_q;
        cnst_d      = cnst_q;
        pre_d       = pre_q;
        len_d       = len_q;
        rdreq_d     = 1'b0;
        busy_d      = busy_q;

        if (issue) begin
            rem_d = rem_q - LEN_ONE;
            // hold the address on stop_addr once the final read is out
            if (rem_q != LEN_ONE) addr_d = addr_q + ADR_ONE;
        end

        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    e0_d = wvb_data;
                    l0_d = pend_last_q;
                end else begin
                    e1_d = wvb_data;
                    l1_d = pend_last_q;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                l0_d  = l1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = wvb_data;
                    l0_d = pend_last_q;
                end else begin
                    e0_d = e1_q;
                    l0_d = l1_q;
                    e1_d = wvb_data;
                    l1_d = pend_last_q;
                end
            end
            default: ;
        endcase

        case (state_q)
            S_IDLE: begin
                if (en && !hdr_empty) begin
                    ltc_d   = hdr_data[79:32];
                    trig_d  = hdr_data[7:6];
                    cnst_d  = hdr_data[5];
                    pre_d   = hdr_data[4:0];
                    len_d   = hdr_len;
                    addr_d  = hdr_start;
                    rem_d   = hdr_len;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: state_d = S_STREAM;
            S_STREAM: begin
                if (pop && l0_q) begin
                    rdreq_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any event without a pop or done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            cnt_q       <= 2'd0;
            e0_q        <= '0;
            e1_q        <= '0;
            l0_q        <= 1'b0;
            l1_q        <= 1'b0;
            ltc_q       <= '0;
            trig_q      <= '0;
            cnst_q      <= 1'b0;
            pre_q       <= '0;
            len_q       <= '0;
            rdreq_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            cnt_q       <= cnt_d;
            e0_q        <= e0_d;
            e1_q        <= e1_d;
            l0_q        <= l0_d;
            l1_q        <= l1_d;
            ltc_q       <= ltc_d;
            trig_q      <= trig_d;
            cnst_q      <= cnst_d;
            pre_q       <= pre_d;
            len_q       <= len_d;
            rdreq_q     <= rdreq_d;
            busy_q      <= busy_d;
        end
    end

    assign wvb_rd_addr        = addr_q;
    assign hdr_rdreq          = rdreq_q;
    assign wvb_rddone         = rdreq_q;
    assign dout_if.dout       = e0_q;
    assign dout_if.dout_valid = (cnt_q != 2'd0);
    assign dout_if.dout_last  = l0_q && (cnt_q != 2'd0);
    assign evt_ltc            = ltc_q;
    assign evt_trig_src       = trig_q;
    assign evt_cnst_run       = cnst_q;
    assign evt_pre_conf       = pre_q;
    assign evt_len            = len_q;
    assign busy               = busy_q;
endmodule

// File: tb/tb_wvb_reader.sv
// Directed bench for wvb_reader: header FIFO and sync-read RAM models
// (RAM word = its address), stream scoreboard and stall-hold monitor.
module tb_wvb_reader;
    localparam int AW = 12;
    localparam int DW = 22;
    localparam int HW = 80;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [HW-1:0] hdr_data;
    logic          hdr_empty;
    logic          hdr_rdreq;
    logic [AW-1:0] wvb_rd_addr;
    logic [DW-1:0] wvb_data = '0;
    logic          wvb_rddone;
    logic [47:0]   evt_ltc;
    logic [1:0]    evt_trig_src;
    logic          evt_cnst_run;
    logic [4:0]    evt_pre_conf;
    logic [AW:0]   evt_len;
    logic          busy;

    wvb_reader_if #(.P_DATA_WIDTH(DW)) sif();

    wvb_reader #(.P_ADR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_HDR_WIDTH(HW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hdr_data(hdr_data), .hdr_empty(hdr_empty), .hdr_rdreq(hdr_rdreq),
        .wvb_rd_addr(wvb_rd_addr), .wvb_data(wvb_data), .wvb_rddone(wvb_rddone),
        .dout_if(sif),
        .evt_ltc(evt_ltc), .evt_trig_src(evt_trig_src), .evt_cnst_run(evt_cnst_run),
        .evt_pre_conf(evt_pre_conf), .evt_len(evt_len), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // header FIFO (show-ahead) and RAM models
    logic [HW-1:0] hmem [0:7];
    int hwr = 0;
    int hrd = 0;
    assign hdr_empty = (hrd == hwr);
    assign hdr_data  = hmem[hrd[2:0]];
    always @(posedge clk) if (hdr_rdreq) hrd <= hrd + 1;
    always @(posedge clk) wvb_data <= DW'(wvb_rd_addr);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit rnd_rdy = 1'b0;
    always @(posedge clk) begin
        #1;
        sif.dout_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // monitor
    logic [DW-1:0] rx_d[$];
    bit            rx_l[$];
    int rddone_cnt = 0;
    int fv_cyc = -1;
    int la_cyc = -1;
    int dn_cyc = -1;
    bit fv_last = 1'b0;
    bit prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [DW-1:0] prev_d = '0;

    always @(negedge clk) begin
        if (rst_n && prev_v && !prev_r)
            check("hold", {sif.dout_valid, sif.dout_last, sif.dout}, {1'b1, prev_l, prev_d});
        if (sif.dout_valid && fv_cyc < 0) begin
            fv_cyc  = cyc;
            fv_last = sif.dout_last;
        end
        if (sif.dout_valid && sif.dout_ready) begin
            rx_d.push_back(sif.dout);
            rx_l.push_back(sif.dout_last);
            if (sif.dout_last) la_cyc = cyc;
        end
        if (hdr_rdreq || wvb_rddone)
            check("done_pop_pair", {wvb_rddone, hdr_rdreq, hdr_empty, busy}, 4'b1101);
        if (wvb_rddone) begin
            rddone_cnt++;
            dn_cyc = cyc;
        end
        prev_v = sif.dout_valid;
        prev_r = sif.dout_ready;
        prev_l = sif.dout_last;
        prev_d = sif.dout;
    end

    function automatic logic [HW-1:0] mkh(input logic [47:0] ltc, input logic [11:0] s,
                                          input logic [11:0] e, input logic [1:0] ts,
                                          input logic cr, input logic [4:0] pc);
        return {ltc, s, e, ts, cr, pc};
    endfunction

    task automatic push_hdr(input logic [HW-1:0] h);
        hmem[hwr[2:0]] = h;
        hwr++;
    endtask

    task automatic clear_mon();
        rx_d.delete();
        rx_l.delete();
        rddone_cnt = 0;
        fv_cyc = -1;
        la_cyc = -1;
        dn_cyc = -1;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_ltc"}, evt_ltc, 0);
        check({tag, "_dout"}, sif.dout, 0);
        check({tag, "_misc"}, {hdr_rdreq, wvb_rd_addr, wvb_rddone, sif.dout_valid, sif.dout_last,
                               evt_trig_src, evt_cnst_run, evt_pre_conf, evt_len, busy}, 0);
    endtask

    task automatic wait_done(input int n, input int maxc, input string tag);
        for (int i = 0; i < maxc && rddone_cnt < n; i++) @(negedge clk);
        check({tag, "_done"}, rddone_cnt, n);
    endtask

    // words rx_d[off .. off+len-1] must be start..start+len-1 (mod 4096), last only at the end
    task automatic check_seg(input string tag, input int off, input logic [11:0] start, input int len);
        int nbad = 0;
        int nl = 0;
        for (int k = 0; k < len; k++) begin
            logic [11:0] a;
            a = start + 12'(k);
            if (off + k >= rx_d.size()) nbad++;
            else begin
                if (rx_d[off+k] !== DW'(a)) nbad++;
                if (rx_l[off+k]) nl++;
            end
        end
        check({tag, "_data"}, nbad, 0);
        check({tag, "_nlast"}, nl, 1);
        if (off + len - 1 < rx_l.size()) check({tag, "_lastpos"}, rx_l[off+len-1], 1);
    endtask

    int t0 = 0;

    task automatic run_evt(input logic [HW-1:0] h, input int len, input int maxc, input string tag);
        clear_mon();
        @(posedge clk);
        #1;
        push_hdr(h);
        t0 = cyc;
        wait_done(1, maxc, tag);
        repeat (3) @(negedge clk);
        check({tag, "_once"}, rddone_cnt, 1);
        check({tag, "_cnt"}, rx_d.size(), len);
        check_seg(tag, 0, h[31:20], len);
        check({tag, "_len"}, evt_len, len);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 8; i++) hmem[i] = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        en = 1'b1;
        repeat (2) @(negedge clk);

        // single event, timing and header fields
        run_evt(mkh(48'h1234_5678_9ABC, 12'h010, 12'h013, 2'd2, 1'b1, 5'h15), 4, 40, "single");
        check("single_fv_cyc", fv_cyc - t0, 3);
        check("single_last_cyc", la_cyc - t0, 6);
        check("single_done_cyc", dn_cyc - t0, 7);
        check("single_ltc", evt_ltc, 48'h1234_5678_9ABC);
        check("single_flds", {evt_trig_src, evt_cnst_run, evt_pre_conf}, {2'd2, 1'b1, 5'h15});
        check("single_pops", hrd, 1);

        // address wrap
        run_evt(mkh(48'h1, 12'hFFE, 12'h001, 2'd1, 1'b0, 5'h03), 4, 40, "wrap");

        // single-word event
        run_evt(mkh(48'h2, 12'h100, 12'h100, 2'd0, 1'b0, 5'h00), 1, 40, "one");
        check("one_fv_last", fv_last, 1);
        check("one_done_cyc", dn_cyc - t0, 4);

        // full buffer
        run_evt(mkh(48'h3, 12'h100, 12'h0FF, 2'd3, 1'b1, 5'h1F), 4096, 4200, "full");
        check("full_done_cyc", dn_cyc - t0, 4099);

        // random backpressure
        rnd_rdy = 1'b1;
        run_evt(mkh(48'h4, 12'h7F0, 12'h82F, 2'd1, 1'b1, 5'h0A), 64, 600, "rnd");
        rnd_rdy = 1'b0;

        // three queued headers, en dropped during the second
        clear_mon();
        base = hrd;
        @(posedge clk);
        #1;
        push_hdr(mkh(48'h10, 12'h200, 12'h202, 2'd0, 1'b0, 5'h01));
        push_hdr(mkh(48'h11, 12'h300, 12'h304, 2'd0, 1'b0, 5'h02));
        push_hdr(mkh(48'h12, 12'h400, 12'h401, 2'd0, 1'b0, 5'h03));
        wait_done(1, 100, "q1");
        for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
        check("q_ev2_busy", busy, 1);
        en = 1'b0;
        wait_done(2, 100, "q2");
        repeat (10) @(negedge clk);
        check("q_idle_busy", busy, 0);
        check("q_pops2", hrd - base, 2);
        check("q_rx2", rx_d.size(), 8);
        en = 1'b1;
        wait_done(3, 100, "q3");
        repeat (3) @(negedge clk);
        check("q_pops3", hrd - base, 3);
        check("q_rx3", rx_d.size(), 10);
        check("q_empty", hdr_empty, 1);
        check_seg("q_e1", 0, 12'h200, 3);
        check_seg("q_e2", 3, 12'h300, 5);
        check_seg("q_e3", 8, 12'h400, 2);

        // reset mid-stream
        clear_mon();
        base = hrd;
        @(posedge clk);
        #1;
        push_hdr(mkh(48'hABCD, 12'h500, 12'h53F, 2'd2, 1'b0, 5'h07));
        for (int i = 0; i < 100 && rx_d.size() < 10; i++) @(negedge clk);
        check("rst_mid_stream", rx_d.size() >= 10, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async");
        repeat (3) @(negedge clk);
        chk_zero("rst_held");
        check("rst_no_done", rddone_cnt, 0);
        check("rst_no_pop", hrd - base, 0);
        clear_mon();
        rst_n = 1'b1;
        wait_done(1, 300, "rr");
        repeat (3) @(negedge clk);
        check("rr_cnt", rx_d.size(), 64);
        check_seg("rr", 0, 12'h500, 64);
        check("rr_pops", hrd - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wvb_reader.md
# wvb_reader

Reads complete events out of the mDOM waveform buffer, the consumer side of the buffer whose writer and overflow control sit upstream. Pops one event header from the show-ahead header FIFO and fetches waveform words from start_addr through stop_addr, wrapping as needed, from the synchronous-read buffer RAM. Streams those words on a valid/ready interface with the event's header fields held stable. Signals completion with a one-cycle wvb_rddone pulse, coincident with the header pop, so the overflow control frees the space.

## Interface
- P_ADR_WIDTH, 12, waveform buffer address width
- P_DATA_WIDTH, 22, waveform word width
- P_HDR_WIDTH, 80, header bundle width
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  permit starting new events; an event in progress always completes
- hdr_data  input  P_HDR_WIDTH  header FIFO show-ahead output: evt_ltc [79:32], start_addr [31:20], stop_addr [19:8], trig_src [7:6], cnst_run [5], pre_conf [4:0]
- hdr_empty  input  1  header FIFO empty
- hdr_rdreq  output  1  header FIFO pop, one cycle
- wvb_rd_addr  output  P_ADR_WIDTH  buffer RAM read address
- wvb_data  input  P_DATA_WIDTH  RAM read data, valid one cycle after wvb_rd_addr
- wvb_rddone  output  1  event fully read, one-cycle pulse
- dout  output  P_DATA_WIDTH  waveform word
- dout_valid  output  1  dout valid
- dout_last  output  1  qualifies final word of event
- dout_ready  input  1  downstream accepts when high with dout_valid
- evt_ltc  output  48  current event LTC, stable from first dout_valid to wvb_rddone
- evt_trig_src  output  2  current event trigger source
- evt_cnst_run  output  1  current event constant-run flag
- evt_pre_conf  output  5  current event pre-trigger config
- evt_len  output  P_ADR_WIDTH+1  word count of current event
- busy  output  1  high from event latch through wvb_rddone cycle

## Operation
- States: IDLE, LOAD, STREAM, DONE.
- IDLE: when en=1 and hdr_empty=0, latch header fields, go to LOAD. hdr_data is not popped here.
- LOAD: wvb_rd_addr=start_addr, rd counter cleared, go to STREAM.
- STREAM: issue addresses start_addr+k, k=0..evt_len-1, modulo 2^P_ADR_WIDTH.
  - A 2-entry skid buffer absorbs RAM latency.
  - Address increments only when the skid buffer has room for the word in flight.
  - No word is dropped or duplicated under any dout_ready pattern.
  - dout_last=1 on the word from stop_addr.
  - Accepting that word (valid & ready & last) moves the state to DONE.
- DONE: hdr_rdreq=1 and wvb_rddone=1 for exactly one cycle; hdr_data still shows this event, so stop_addr is valid for the overflow control. Go to IDLE.
- evt_len = (stop_addr − start_addr) mod 2^P_ADR_WIDTH + 1, computed at P_ADR_WIDTH+1 bits.
  - start==stop gives 1.
  - stop==start−1 gives 2^P_ADR_WIDTH (4096 at default); the full buffer is read.
- en deasserted mid-event has no effect until IDLE.
- Reset (rst_n low, any time): state IDLE; all outputs 0 (wvb_rd_addr, dout, evt_* included); skid buffer emptied. An aborted event produces no wvb_rddone and no pop.

## Timing
- Cycle 0: IDLE samples en=1, hdr_empty=0. Cycle 1: LOAD. Cycle 2: first address issued. Cycle 3: first dout_valid=1.
- With dout_ready held 1: one word per cycle. The last word is accepted at cycle evt_len+2, DONE at cycle evt_len+3, IDLE at cycle evt_len+4. The next event's cycle 0 is no earlier than cycle evt_len+4.
- dout, dout_last and dout_valid hold while dout_valid=1 and dout_ready=0.
- dout_valid may assert with dout_ready low; it never deasserts without acceptance.
- hdr_rdreq is never asserted while hdr_empty=1.

## Test plan
- Single event, start=0x010, stop=0x013, RAM word = address, ready=1.
  - dout 0x010..0x013 on cycles 3–6; last on 0x013.
  - evt_len=4; wvb_rddone and hdr_rdreq pulse on cycle 7.
- Wrap event, start=0xFFE, stop=0x001.
  - dout 0xFFE, 0xFFF, 0x000, 0x001; evt_len=4.
- Edge lengths.
  - start=stop=0x100: one word, dout_last with the first valid.
  - start=0x100, stop=0x0FF: 4096 words, evt_len=0x1000.
- Random dout_ready (50%) over a 64-word event.
  - Scoreboard shows exact in-order data and no duplicates.
  - Outputs stable while stalled; exactly one wvb_rddone.
- Three queued headers, ready=1, en toggled low during event 2.
  - Event 2 completes; event 3 starts only after en returns high; three pops total.
- rst_n pulsed low mid-STREAM.
  - All outputs 0 asynchronously; no wvb_rddone or hdr_rdreq.
  - After release, the same header (not popped) is read again from its start.
